jump_unit_ras: RTL and testbench
================================

Name: jump_unit_ras

Overview:
- Parametrised successor to the RV32I jump unit.
- Resolves JAL/JALR, writes the link value, and redirects the PC.
- Suppresses a configurable number of wrong-path instructions after a taken jump.
- Maintains a return-address stack (RAS) following the RISC-V link-register hint rules.
- Flags misaligned jump targets instead of redirecting.
- Sits in the execute stage beside the branch unit; the fetch stage consumes ras_top as a return prediction.

Parameters:
XLEN, 32, data/address width
RAS_DEPTH, 4, number of RAS entries (power of two, >=2)
FLUSH_CYCLES, 1, cycles ignore_curr_inst stays high after a taken jump (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_valid  in  1  instruction in execute is valid
jump_control  in  2  00 none, 01 JAL, 10 JALR, 11 reserved (treated as none)
pc  in  XLEN  PC of current instruction
imm  in  XLEN  sign-extended immediate
rs1_val  in  XLEN  rs1 operand
rs1_idx  in  5  rs1 register index
rd_idx  in  5  rd register index
rd_write_control  out  1  write rd
rd_write_val  out  XLEN  link value
pc_update_control  out  1  redirect fetch
pc_update_val  out  XLEN  jump target
ignore_curr_inst  out  1  current instruction is wrong-path; suppress it
misaligned_exc  out  1  target not 4-byte aligned
ras_top  out  XLEN  top-of-stack return prediction
ras_valid  out  1  RAS non-empty
ras_count  out  $clog2(RAS_DEPTH)+1  occupied entries

Behaviour:
- Reset i_rst, asynchronous, active-low; clock i_clk. Reset clears flush counter, RAS pointer and count, and all RAS entries. After reset: ignore_curr_inst=0, ras_valid=0, ras_top=0, ras_count=0.
- active = i_valid & ~ignore_curr_inst & (jump_control is 01 or 10).
- Target (combinational):
  - JAL: pc+imm.
  - JALR: (rs1_val+imm) with bit0 forced to 0.
  - Sums are modulo 2^XLEN.
- misaligned_exc = active & target[1].
- taken = active & ~misaligned_exc.
- Combinational outputs:
  - taken: rd_write_control=1 (0 if rd_idx=0), rd_write_val=pc+4, pc_update_control=1, pc_update_val=target.
  - Otherwise all four are 0, including when misaligned_exc=1.
- Flush counter:
  - On the clock edge with taken=1, load FLUSH_CYCLES.
  - While counter>0 and taken=0, decrement each cycle.
  - ignore_curr_inst = (counter!=0), registered.
  - It rises the cycle after taken and stays high exactly FLUSH_CYCLES cycles.
  - Instructions presented while ignore_curr_inst=1 never jump, write, push, or pop.
- RAS (updates only on edges where taken=1; link = index 1 or 5):
  - rd link, rs1 not link (or JAL): push pc+4.
  - JALR, rd not link, rs1 link: pop.
  - JALR, both link, rs1_idx!=rd_idx: pop then push. Top is replaced with pc+4; count unchanged unless empty, then count=1.
  - JALR, both link, rs1_idx==rd_idx: push.
  - Neither is link: no change.
- RAS boundaries:
  - Circular buffer. Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change, count stays 0.
  - ras_top shows the entry at the top pointer and is 0 when empty.
- Misaligned or non-taken instructions never touch the RAS or the counter.
- Reset mid-flush clears the counter immediately (ignore_curr_inst=0).

Test Plan:
- Reset then JAL: pc=0x100, imm=0x20, rd=1 → rd_write_val=0x104, pc_update_val=0x120; next cycle ignore_curr_inst=1 for 1 cycle; ras_top=0x104, ras_count=1.
- JALR bit0 clear: rs1_val=0x201, imm=0, rd=0, rs1=5 → pc_update_val=0x200, rd_write_control=0; pop leaves ras_count=0.
- Misaligned: JAL pc=0x100, imm=0x2 → misaligned_exc=1, pc_update_control=0, rd_write_control=0, RAS unchanged, no flush.
- RAS overflow with RAS_DEPTH=4: 5 JALs with rd=1 at pc 0x0/0x10/0x20/0x30/0x40 → count=4, ras_top=0x44; then 4 returns pop 0x44, 0x34, 0x24, 0x14; a 5th pop leaves count=0, ras_valid=0.
- Flush suppression with FLUSH_CYCLES=3: JAL taken, then JALRs on the next 3 cycles → no pc_update, no RAS change; 4th-cycle JAL is taken.
- Pop-then-push: RAS holds 0x500; JALR rd=1, rs1=5, pc=0x80 → ras_top=0x84, ras_count=1. Also assert i_rst low during flush → ignore_curr_inst=0 asynchronously.

Source files
------------

// File: rtl/jump_unit_ras.sv
// Execute-stage jump unit: resolves JAL/JALR, writes the link value, redirects fetch,
// squashes wrong-path instructions after a taken jump and keeps a return-address stack.
module jump_unit_ras #(
  parameter int XLEN         = 32,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [1:0]                   jump_control,
  input  logic [XLEN-1:0]              pc,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              rs1_val,
  input  logic [4:0]                   rs1_idx,
  input  logic [4:0]                   rd_idx,
  output logic                         rd_write_control,
  output logic [XLEN-1:0]              rd_write_val,
  output logic                         pc_update_control,
  output logic [XLEN-1:0]              pc_update_val,
  output logic                         ignore_curr_inst,
  output logic                         misaligned_exc,
  output logic [XLEN-1:0]              ras_top,
  output logic                         ras_valid,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP
  } ras_op_e;

  // x1 (ra) and x5 (t0) are the link registers for return-address hints.
  function automatic logic is_link(input logic [4:0] idx);
    return (idx == 5'd1) || (idx == 5'd5);
  endfunction

  logic [FC_W-1:0]  flush_cnt;
  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] top_ptr_inc;
  logic [PTR_W-1:0] top_ptr_dec;

  logic             is_jal;
  logic             is_jalr;
  logic             active;
  logic             taken;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  link_val;
  logic             rd_link;
  logic             rs1_link;
  logic             ras_empty;
  logic             ras_full;
  ras_op_e          ras_op;

  assign ignore_curr_inst = (flush_cnt != '0);

  assign is_jal   = (jump_control == 2'b01);
  assign is_jalr  = (jump_control == 2'b10);
  assign active   = i_valid & ~ignore_curr_inst & (is_jal | is_jalr);

  assign jalr_sum = rs1_val + imm;
  assign target   = is_jalr ? (jalr_sum & ~XLEN'(1)) : (pc + imm);
  assign link_val = pc + XLEN'(4);

  assign misaligned_exc = active & target[1];
  assign taken          = active & ~target[1];

  always_comb begin
    rd_write_control  = 1'b0;
    rd_write_val      = '0;
    pc_update_control = 1'b0;
    pc_update_val     = '0;
    if (taken) begin
      rd_write_control  = (rd_idx != 5'd0);
      rd_write_val      = link_val;
      pc_update_control = 1'b1;
      pc_update_val     = target;
    end
  end

  assign rd_link   = is_link(rd_idx);
  assign rs1_link  = is_link(rs1_idx);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

  // Link-register hint table: JAL only ever pushes; JALR may pop, push or swap.
  always_comb begin
    ras_op = RAS_NONE;
    if (taken) begin
      if (is_jal) begin
        if (rd_link) ras_op = RAS_PUSH;
      end else begin
        unique case ({rd_link, rs1_link})
          2'b10:   ras_op = RAS_PUSH;
          2'b01:   ras_op = RAS_POP;
          2'b11:   ras_op = (rs1_idx == rd_idx) ? RAS_PUSH : RAS_SWAP;
          default: ras_op = RAS_NONE;
        endcase
      end
    end
  end

  assign top_ptr_inc = top_ptr + PTR_W'(1);
  assign top_ptr_dec = top_ptr - PTR_W'(1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      flush_cnt <= '0;
    end else if (taken) begin
      flush_cnt <= FC_W'(FLUSH_CYCLES);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  // Circular stack: a push on a full stack wraps onto the oldest slot.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      top_ptr   <= '0;
      ras_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
    end else begin
      unique case (ras_op)
        RAS_PUSH: begin
          entries[top_ptr_inc] <= link_val;
          top_ptr              <= top_ptr_inc;
          if (!ras_full) ras_count <= ras_count + CNT_W'(1);
        end
        RAS_POP: begin
          if (!ras_empty) begin
            top_ptr   <= top_ptr_dec;
            ras_count <= ras_count - CNT_W'(1);
          end
        end
        RAS_SWAP: begin
          if (ras_empty) begin
            entries[top_ptr_inc] <= link_val;
            top_ptr              <= top_ptr_inc;
            ras_count            <= CNT_W'(1);
          end else begin
            entries[top_ptr] <= link_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign ras_valid = ~ras_empty;
  assign ras_top   = ras_empty ? '0 : entries[top_ptr];

endmodule

// File: tb/tb_jump_unit_ras.sv
// Bench for jump_unit_ras: two instances (FLUSH_CYCLES 1 and 3) share stimulus and are
// compared each cycle with a list-based reference model plus directed constant checks.
module tb_jump_unit_ras;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [1:0]  jump_control;
  logic [31:0] pc, imm, rs1_val;
  logic [4:0]  rs1_idx, rd_idx;

  logic        rdw [2];
  logic [31:0] rdv [2];
  logic        pcu [2];
  logic [31:0] pcv [2];
  logic        ign [2];
  logic        mis [2];
  logic [31:0] top [2];
  logic        rv  [2];
  logic [2:0]  cnt [2];

  always #5 i_clk = ~i_clk;

  jump_unit_ras #(.XLEN(32), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(1)) u_f1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .jump_control(jump_control),
    .pc(pc), .imm(imm), .rs1_val(rs1_val), .rs1_idx(rs1_idx), .rd_idx(rd_idx),
    .rd_write_control(rdw[0]), .rd_write_val(rdv[0]), .pc_update_control(pcu[0]),
    .pc_update_val(pcv[0]), .ignore_curr_inst(ign[0]), .misaligned_exc(mis[0]),
    .ras_top(top[0]), .ras_valid(rv[0]), .ras_count(cnt[0])
  );

  jump_unit_ras #(.XLEN(32), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(3)) u_f3 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .jump_control(jump_control),
    .pc(pc), .imm(imm), .rs1_val(rs1_val), .rs1_idx(rs1_idx), .rd_idx(rd_idx),
    .rd_write_control(rdw[1]), .rd_write_val(rdv[1]), .pc_update_control(pcu[1]),
    .pc_update_val(pcv[1]), .ignore_curr_inst(ign[1]), .misaligned_exc(mis[1]),
    .ras_top(top[1]), .ras_valid(rv[1]), .ras_count(cnt[1])
  );

  logic [103:0] obs [2];
  assign obs[0] = {rdw[0], rdv[0], pcu[0], pcv[0], ign[0], mis[0], top[0], rv[0], cnt[0]};
  assign obs[1] = {rdw[1], rdv[1], pcu[1], pcv[1], ign[1], mis[1], top[1], rv[1], cnt[1]};

  // Reference model: a bottom-first list of return addresses and a remaining-squash count.
  int           m_flush [2];
  int           m_n     [2];
  logic [31:0]  m_stk   [2][DEPTH];
  bit           m_taken [2];
  logic [103:0] exp_obs [2];
  int           errors = 0;
  int           checks = 0;

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic int flush_len(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_flush[k] = 0;
      m_n[k]     = 0;
    end
  endtask

  task automatic model_push(input int k, input logic [31:0] v);
    if (m_n[k] == DEPTH) begin
      for (int i = 0; i < DEPTH - 1; i++) m_stk[k][i] = m_stk[k][i+1];
      m_stk[k][DEPTH-1] = v;
    end else begin
      m_stk[k][m_n[k]] = v;
      m_n[k]++;
    end
  endtask

  task automatic model_expect();
    for (int k = 0; k < 2; k++) begin
      bit          ignore, act, misx, tk, jal, jalr;
      logic [31:0] tgt, t;
      ignore = (m_flush[k] != 0);
      jal    = (jump_control == 2'b01);
      jalr   = (jump_control == 2'b10);
      act    = i_valid && !ignore && (jal || jalr);
      tgt    = jalr ? ((rs1_val + imm) & ~32'h1) : (pc + imm);
      misx   = act && tgt[1];
      tk     = act && !misx;
      t      = (m_n[k] > 0) ? m_stk[k][m_n[k]-1] : 32'h0;
      m_taken[k] = tk;
      exp_obs[k] = {tk && (rd_idx != 5'd0), (tk ? pc + 32'd4 : 32'h0), tk,
                    (tk ? tgt : 32'h0), ignore, misx, t, (m_n[k] > 0), 3'(m_n[k])};
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] v;
      bit rdl, rsl;
      v   = pc + 32'd4;
      rdl = is_link(rd_idx);
      rsl = is_link(rs1_idx);
      if (m_taken[k]) begin
        m_flush[k] = flush_len(k);
        if (jump_control == 2'b01) begin
          if (rdl) model_push(k, v);
        end else if (rdl && !rsl) begin
          model_push(k, v);
        end else if (!rdl && rsl) begin
          if (m_n[k] > 0) m_n[k]--;
        end else if (rdl && rsl) begin
          if (rs1_idx == rd_idx || m_n[k] == 0) model_push(k, v);
          else m_stk[k][m_n[k]-1] = v;
        end
      end else if (m_flush[k] > 0) begin
        m_flush[k]--;
      end
    end
  endtask

  task automatic apply(input logic v, input logic [1:0] jc, input logic [31:0] p,
                       input logic [31:0] im, input logic [31:0] r1v,
                       input logic [4:0] r1i, input logic [4:0] rdi);
    @(negedge i_clk);
    i_valid = v; jump_control = jc; pc = p; imm = im; rs1_val = r1v;
    rs1_idx = r1i; rd_idx = rdi;
    #1;
    model_expect();
  endtask

  task automatic commit();
    model_commit();
    @(posedge i_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      commit();
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_valid = 1'b0; jump_control = 2'b00; pc = '0; imm = '0;
    rs1_val = '0; rs1_idx = '0; rd_idx = '0;
    model_reset();
    #3;
    model_expect();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL reset_model[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
      checks++;
      if ({ign[k], rv[k], top[k], cnt[k]} !== 37'h0) begin
        errors++; $display("FAIL reset_state[%0d]: got ign=%b valid=%b top=%h count=%0d expected all 0",
                           k, ign[k], rv[k], top[k], cnt[k]);
      end
    end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_jal_basic();
    apply(1'b1, 2'b01, 32'h100, 32'h20, 32'h0, 5'd0, 5'd1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL jal_cycle0[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
    end
    checks++;
    if ({rdw[0], rdv[0], pcu[0], pcv[0]} !== {1'b1, 32'h104, 1'b1, 32'h120}) begin
      errors++; $display("FAIL jal_outputs: got rdw=%b link=%h redirect=%b target=%h expected 1/104/1/120",
                         rdw[0], rdv[0], pcu[0], pcv[0]);
    end
    commit();
    apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL jal_cycle1[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
    end
    checks++;
    if ({ign[0], top[0], cnt[0]} !== {1'b1, 32'h104, 3'd1}) begin
      errors++; $display("FAIL jal_after: got ign=%b top=%h count=%0d expected 1/104/1", ign[0], top[0], cnt[0]);
    end
    commit();
    apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if (ign[0] !== 1'b0 || ign[1] !== 1'b1) begin
      errors++; $display("FAIL jal_flush_len: got ign f1=%b f3=%b expected 0/1", ign[0], ign[1]);
    end
    commit();
    idle(2);
  endtask

  task automatic test_jalr_bit0();
    apply(1'b1, 2'b10, 32'h300, 32'h0, 32'h201, 5'd5, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL jalr_cycle0[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
    end
    checks++;
    if ({pcu[0], pcv[0], rdw[0]} !== {1'b1, 32'h200, 1'b0}) begin
      errors++; $display("FAIL jalr_bit0: got redirect=%b target=%h rdw=%b expected 1/200/0", pcu[0], pcv[0], rdw[0]);
    end
    commit();
    apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({cnt[0], rv[0]} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL jalr_pop: got count=%0d valid=%b expected 0/0", cnt[0], rv[0]);
    end
    commit();
    idle(3);
  endtask

  task automatic test_misaligned();
    apply(1'b1, 2'b01, 32'h100, 32'h2, 32'h0, 5'd0, 5'd1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL misaligned_cycle0[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
    end
    checks++;
    if ({mis[0], pcu[0], rdw[0], rdv[0], pcv[0]} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      errors++; $display("FAIL misaligned_outputs: got exc=%b redirect=%b rdw=%b expected 1/0/0", mis[0], pcu[0], rdw[0]);
    end
    commit();
    apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({ign[0], ign[1], cnt[0]} !== {1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL misaligned_after: got ign=%b/%b count=%0d expected 0/0/0", ign[0], ign[1], cnt[0]);
    end
    commit();
  endtask

  task automatic test_overflow();
    logic [31:0] tops [4];
    tops[0] = 32'h44; tops[1] = 32'h34; tops[2] = 32'h24; tops[3] = 32'h14;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 2'b01, 32'(i * 16), 32'h100, 32'h0, 5'd0, 5'd1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_obs[k]) begin
          errors++; $display("FAIL overflow_push%0d[%0d]: got %h expected %h", i, k, obs[k], exp_obs[k]);
        end
      end
      commit();
      idle(3);
    end
    apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({cnt[0], top[0], cnt[1], top[1]} !== {3'd4, 32'h44, 3'd4, 32'h44}) begin
      errors++; $display("FAIL overflow_full: got count=%0d top=%h expected 4/44", cnt[0], top[0]);
    end
    commit();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 2'b10, 32'h800, 32'h0, 32'h1000, 5'd1, 5'd0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_obs[k]) begin
          errors++; $display("FAIL overflow_pop%0d[%0d]: got %h expected %h", i, k, obs[k], exp_obs[k]);
        end
      end
      if (i < 4) begin
        checks++;
        if (top[0] !== tops[i]) begin
          errors++; $display("FAIL overflow_top%0d: got %h expected %h", i, top[0], tops[i]);
        end
      end
      commit();
      idle(3);
    end
    apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({cnt[0], rv[0], cnt[1], rv[1]} !== {3'd0, 1'b0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL overflow_empty: got count=%0d valid=%b expected 0/0", cnt[0], rv[0]);
    end
    commit();
  endtask

  task automatic test_flush();
    apply(1'b1, 2'b01, 32'h200, 32'h40, 32'h0, 5'd0, 5'd1);
    commit();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'b10, 32'h300, 32'h0, 32'h600, 5'd5, 5'd1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_obs[k]) begin
          errors++; $display("FAIL flush_jalr%0d[%0d]: got %h expected %h", i, k, obs[k], exp_obs[k]);
        end
      end
      checks++;
      if ({pcu[1], rdw[1], cnt[1], top[1]} !== {1'b0, 1'b0, 3'd1, 32'h204}) begin
        errors++; $display("FAIL flush_suppress%0d: got redirect=%b rdw=%b count=%0d top=%h expected 0/0/1/204",
                           i, pcu[1], rdw[1], cnt[1], top[1]);
      end
      commit();
    end
    apply(1'b1, 2'b01, 32'h400, 32'h10, 32'h0, 5'd0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL flush_release[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
    end
    checks++;
    if ({pcu[1], pcv[1], cnt[1], top[1]} !== {1'b1, 32'h410, 3'd1, 32'h204}) begin
      errors++; $display("FAIL flush_taken: got redirect=%b target=%h count=%0d top=%h expected 1/410/1/204",
                         pcu[1], pcv[1], cnt[1], top[1]);
    end
    commit();
    idle(3);
  endtask

  task automatic test_pop_push();
    apply(1'b1, 2'b10, 32'h800, 32'h0, 32'h1000, 5'd1, 5'd0);
    commit();
    idle(3);
    apply(1'b1, 2'b01, 32'h4FC, 32'h104, 32'h0, 5'd0, 5'd5);
    commit();
    idle(3);
    apply(1'b1, 2'b10, 32'h80, 32'h0, 32'h500, 5'd5, 5'd1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL poppush_cycle0[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
      checks++;
      if ({top[k], cnt[k]} !== {32'h500, 3'd1}) begin
        errors++; $display("FAIL poppush_before[%0d]: got top=%h count=%0d expected 500/1", k, top[k], cnt[k]);
      end
    end
    commit();
    apply(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({top[k], cnt[k]} !== {32'h84, 3'd1}) begin
        errors++; $display("FAIL poppush_after[%0d]: got top=%h count=%0d expected 84/1", k, top[k], cnt[k]);
      end
    end
    commit();
    idle(3);
  endtask

  task automatic test_async_reset();
    apply(1'b1, 2'b01, 32'h10, 32'h10, 32'h0, 5'd0, 5'd1);
    commit();
    #1;
    checks++;
    if (ign[0] !== 1'b1 || ign[1] !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got ign=%b/%b expected 1/1", ign[0], ign[1]);
    end
    #1;
    i_valid = 1'b0; jump_control = 2'b00;
    i_rst = 1'b0;
    model_reset();
    #1;
    model_expect();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_obs[k]) begin
        errors++; $display("FAIL areset_model[%0d]: got %h expected %h", k, obs[k], exp_obs[k]);
      end
      checks++;
      if ({ign[k], cnt[k], rv[k]} !== 5'b0) begin
        errors++; $display("FAIL areset_state[%0d]: got ign=%b count=%0d valid=%b expected 0/0/0",
                           k, ign[k], cnt[k], rv[k]);
      end
    end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] idx_tab [6];
    idx_tab[0] = 5'd0; idx_tab[1] = 5'd1; idx_tab[2] = 5'd5;
    idx_tab[3] = 5'd2; idx_tab[4] = 5'd1; idx_tab[5] = 5'd5;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] p, im, r;
      p  = $urandom & 32'hFFFF_FFFC;
      im = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      r  = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), p, im, r,
            idx_tab[$urandom_range(0, 5)], idx_tab[$urandom_range(0, 5)]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_obs[k]) begin
          errors++; $display("FAIL random%0d[%0d]: got %h expected %h", n, k, obs[k], exp_obs[k]);
        end
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_jal_basic();
    test_jalr_bit0();
    test_misaligned();
    test_overflow();
    test_flush();
    test_pop_push();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
